mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide engine that owns the HI/LO register pair.
- Forms the sequential counterpart of the single-cycle combinational ALU: the ALU finishes add/sub in one cycle, while this block executes MULT/MULTU/DIV/DIVU iteratively and also services MTHI/MTLO.
- The datapath issues a request with Start, stalls while Busy is high, and reads HI/LO once Done pulses.

---
 rtl/mult_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// =============================================================================
// Module : mult_div_unit
// Desc   : Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; also MTHI/MTLO.
//          Define MD_EARLY_TERM_EN to end a multiply once the multiplier is spent.
// Rev    : 1.0
// =============================================================================
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [2:0]            MDOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);
    localparam int               c_CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [2:0]       c_OP_MULT  = 3'b000;
    localparam logic [2:0]       c_OP_MULTU = 3'b001;
    localparam logic [2:0]       c_OP_DIV   = 3'b010;
    localparam logic [2:0]       c_OP_DIVU  = 3'b011;
    localparam logic [2:0]       c_OP_MTHI  = 3'b100;
    localparam logic [2:0]       c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [c_CNT_W-1:0]          r_cnt;
    logic                        r_is_mul;
    logic                        r_neg_q;
    logic                        r_neg_r;
    logic                        r_dbz_pend;
    logic [2*DATA_WIDTH-1:0]     r_mcand;
    logic [2*DATA_WIDTH-1:0]     r_acc;
    logic [DATA_WIDTH-1:0]       r_mplier;
    logic [DATA_WIDTH-1:0]       r_quo;
    logic [DATA_WIDTH-1:0]       r_rem;
    logic [DATA_WIDTH-1:0]       r_div;
    logic [DATA_WIDTH-1:0]       r_hi;
    logic [DATA_WIDTH-1:0]       r_lo;
    logic                        r_done;
    logic                        r_dbz;

    logic                        w_accept;
    logic                        w_is_mul;
    logic                        w_is_div;
    logic                        w_signed;
    logic                        w_a_neg;
    logic                        w_b_neg;
    logic [DATA_WIDTH-1:0]       w_a_mag;
    logic [DATA_WIDTH-1:0]       w_b_mag;
    logic [DATA_WIDTH-1:0]       w_mplier_next;
    logic                        w_last;
    logic                        w_mul_exit;
    logic [DATA_WIDTH:0]         w_rem_shift;
    logic [DATA_WIDTH:0]         w_rem_diff;
    logic [2*DATA_WIDTH-1:0]     w_prod;
    logic [DATA_WIDTH-1:0]       w_quo_res;
    logic [DATA_WIDTH-1:0]       w_rem_res;

    assign w_accept = (r_state == S_IDLE) && Start && (MDOperation <= c_OP_MTLO);
    assign w_is_mul = (MDOperation == c_OP_MULT) || (MDOperation == c_OP_MULTU);
    assign w_is_div = (MDOperation == c_OP_DIV)  || (MDOperation == c_OP_DIVU);
    assign w_signed = (MDOperation == c_OP_MULT) || (MDOperation == c_OP_DIV);
    assign w_a_neg  = w_signed && A[DATA_WIDTH-1];
    assign w_b_neg  = w_signed && B[DATA_WIDTH-1];
    assign w_a_mag  = w_a_neg ? -A : A;
    assign w_b_mag  = w_b_neg ? -B : B;

    assign w_mplier_next = r_mplier >> 1;
    assign w_last        = (r_cnt == c_LAST);
`ifdef MD_EARLY_TERM_EN
    assign w_mul_exit    = w_last || (w_mplier_next == '0);
`else
    assign w_mul_exit    = w_last;
`endif

    // Restoring step: bit DATA_WIDTH of the difference is the borrow (trial failed)
    assign w_rem_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_div};

    assign w_prod    = r_neg_q ? -r_acc : r_acc;
    assign w_quo_res = r_neg_q ? -r_quo : r_quo;
    assign w_rem_res = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)      w_state_next = S_MUL;
                else if (w_accept && w_is_div) w_state_next = (B == '0) ? S_FINISH : S_DIV;
            end
            S_MUL:    if (w_mul_exit) w_state_next = S_FINISH;
            S_DIV:    if (w_last)     w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_is_mul   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dbz      <= 1'b0;
                        r_cnt      <= '0;
                        r_is_mul   <= w_is_mul;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_dbz_pend <= w_is_div && (B == '0);
                        r_mcand    <= {{DATA_WIDTH{1'b0}}, w_a_mag};
                        r_acc      <= '0;
                        r_mplier   <= w_b_mag;
                        r_quo      <= w_a_mag;
                        r_rem      <= '0;
                        r_div      <= w_b_mag;
                        if (MDOperation == c_OP_MTHI) begin
                            r_hi   <= A;
                            r_done <= 1'b1;
                        end
                        if (MDOperation == c_OP_MTLO) begin
                            r_lo   <= A;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_rem <= w_rem_diff[DATA_WIDTH] ? w_rem_shift[DATA_WIDTH-1:0]
                                                    : w_rem_diff[DATA_WIDTH-1:0];
                    r_quo <= {r_quo[DATA_WIDTH-2:0], ~w_rem_diff[DATA_WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    if (r_dbz_pend) begin
                        r_dbz <= 1'b1;
                    end else if (r_is_mul) begin
                        {r_hi, r_lo} <= w_prod;
                    end else begin
                        r_hi <= w_rem_res;
                        r_lo <= w_quo_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// =============================================================================
// Module : tb_mult_div_unit
// Desc   : Scoreboard bench for mult_div_unit with directed vectors.
// Rev    : 1.0
// =============================================================================
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  MDOperation = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy, Done, DivByZero;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;
    exp_t        q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOperation(MDOperation),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every Done is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (reset && Done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_hi"}, {32'h0, HI}, {32'h0, e.hi});
                check({e.name, "_lo"}, {32'h0, LO}, {32'h0, e.lo});
                check({e.name, "_dbz"}, {63'h0, DivByZero}, {63'h0, e.dbz});
            end
        end
    end

    function automatic int mul_iters(input logic [31:0] b, input bit sgn);
        logic [31:0] m;
        int n;
        m = (sgn && b[31]) ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`ifndef MD_EARLY_TERM_EN
        n = 32;
`endif
        return n;
    endfunction

    task automatic expect_res(input string name, input logic [31:0] hi,
                              input logic [31:0] lo, input logic dbz);
        exp_t e;
        e.name = name; e.hi = hi; e.lo = lo; e.dbz = dbz;
        q.push_back(e);
        m_hi = hi;
        m_lo = lo;
    endtask

    // Returns at the negedge that follows accepting edge k
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1; MDOperation = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Counts edges after k until Done is seen; lat = -1 on timeout
    task automatic wait_done(input int max_cyc, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int i = 0; i <= max_cyc; i++) begin
            if (Done) begin
                lat = i;
                break;
            end
            if (Busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic finish_op(input string name, input int exp_lat);
        int lat, bc;
        wait_done(200, lat, bc);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        check({name, "_busy_at_done"}, {63'h0, Busy}, 64'h0);
        @(negedge clk);
        check({name, "_done_pulse"}, {63'h0, Done}, 64'h0);
    endtask

    task automatic mt(input string name, input logic [2:0] op, input logic [31:0] a);
        expect_res(name, (op == 3'b100) ? a : m_hi, (op == 3'b101) ? a : m_lo, 1'b0);
        issue(op, a, 32'h0);
        check({name, "_done"}, {63'h0, Done}, 64'h1);
        check({name, "_busy"}, {63'h0, Busy}, 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, cnt;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'h0, Busy}, 64'h0);
        check("reset_done", {63'h0, Done}, 64'h0);
        check("reset_dbz", {63'h0, DivByZero}, 64'h0);
        check("reset_hilo", {HI, LO}, 64'h0);
        reset = 1'b1;

        expect_res("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu_max", mul_iters(32'hFFFFFFFF, 1'b0) + 1);

        expect_res("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        issue(3'b000, 32'hFFFFFFFD, 32'd7);
        finish_op("mult_neg", mul_iters(32'd7, 1'b1) + 1);

        expect_res("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        finish_op("div_neg", 33);

        expect_res("divu", 32'd1, 32'd3, 1'b0);
        issue(3'b011, 32'd7, 32'd2);
        finish_op("divu", 33);

        expect_res("div_ovf", 32'h0, 32'h80000000, 1'b0);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div_ovf", 33);

        mt("mthi_pre", 3'b100, 32'h11);
        mt("mtlo_pre", 3'b101, 32'h22);
        expect_res("divu_zero", 32'h11, 32'h22, 1'b1);
        issue(3'b011, 32'd5, 32'd0);
        finish_op("divu_zero", 1);
        repeat (3) @(negedge clk);
        check("dbz_sticky", {63'h0, DivByZero}, 64'h1);

        expect_res("multu_small", 32'h0, 32'd12, 1'b0);
        issue(3'b001, 32'd3, 32'd4);
        check("dbz_cleared", {63'h0, DivByZero}, 64'h0);
        finish_op("multu_small", mul_iters(32'd4, 1'b0) + 1);

        // Start while busy must be dropped
        expect_res("multu_busy", 32'h000091A2, 32'h80012345, 1'b0);
        issue(3'b001, 32'h00012345, 32'h80000001);
        repeat (4) @(negedge clk);
        Start = 1'b1; MDOperation = 3'b011; A = 32'd1; B = 32'd1;
        @(negedge clk);
        Start = 1'b0;
        wait_done(200, lat, bc);
        check("busy_start_latency", 64'(lat), 64'(mul_iters(32'h80000001, 1'b0) + 1 - 5));
        repeat (40) @(negedge clk);

        // Abort via reset mid-multiply
        issue(3'b001, 32'h0000FFFF, 32'h80000000);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'h0, Busy}, 64'h0);
        check("abort_done", {63'h0, Done}, 64'h0);
        check("abort_hilo", {HI, LO}, 64'h0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) cnt++;
        end
        check("abort_quiet", 64'(cnt), 64'h0);

        expect_res("multu_post", 32'h0, 32'd12, 1'b0);
        issue(3'b001, 32'd3, 32'd4);
        finish_op("multu_post", mul_iters(32'd4, 1'b0) + 1);

        // Back-to-back MTHI/MTLO
        expect_res("mthi_b2b", 32'h12345678, m_lo, 1'b0);
        expect_res("mtlo_b2b", 32'h12345678, 32'h9ABCDEF0, 1'b0);
        @(negedge clk);
        Start = 1'b1; MDOperation = 3'b100; A = 32'h12345678;
        @(negedge clk);
        check("mthi_b2b_done", {63'h0, Done}, 64'h1);
        check("mthi_b2b_busy", {63'h0, Busy}, 64'h0);
        MDOperation = 3'b101; A = 32'h9ABCDEF0;
        @(negedge clk);
        Start = 1'b0;
        check("mtlo_b2b_done", {63'h0, Done}, 64'h1);
        check("mtlo_b2b_busy", {63'h0, Busy}, 64'h0);
        @(negedge clk);
        check("mt_b2b_end", {63'h0, Done}, 64'h0);

        // Reserved opcode is ignored
        issue(3'b110, 32'h5, 32'h5);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done || Busy) cnt++;
            @(negedge clk);
        end
        check("reserved_ignored", 64'(cnt), 64'h0);
        check("reserved_hilo", {HI, LO}, {32'h12345678, 32'h9ABCDEF0});

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
